// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment marquee.
// Segment codes are active-low, with bit0 = segment a up to bit6 = segment g.
// Also holds the elaboration-time helpers that size the index ports and
// work out the constant digit offsets.
package seg7_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam int SEG_W = 7;

  localparam logic [6:0] SEG_BLANK  = 7'h7F;

  localparam logic [6:0] GLYPH_0    = 7'h40;
  localparam logic [6:0] GLYPH_1    = 7'h79;
  localparam logic [6:0] GLYPH_2    = 7'h24;
  localparam logic [6:0] GLYPH_3    = 7'h30;
  localparam logic [6:0] GLYPH_4    = 7'h19;
  localparam logic [6:0] GLYPH_5    = 7'h12;
  localparam logic [6:0] GLYPH_6    = 7'h02;
  localparam logic [6:0] GLYPH_7    = 7'h78;
  localparam logic [6:0] GLYPH_8    = 7'h00;
  localparam logic [6:0] GLYPH_9    = 7'h10;
  localparam logic [6:0] GLYPH_A    = 7'h08;
  localparam logic [6:0] GLYPH_B    = 7'h03;
  localparam logic [6:0] GLYPH_C    = 7'h46;
  localparam logic [6:0] GLYPH_D    = 7'h21;
  localparam logic [6:0] GLYPH_E    = 7'h06;
  localparam logic [6:0] GLYPH_F    = 7'h0E;
  localparam logic [6:0] GLYPH_H    = 7'h09;
  localparam logic [6:0] GLYPH_L    = 7'h47;
  localparam logic [6:0] GLYPH_O    = 7'h40;
  localparam logic [6:0] GLYPH_DASH = 7'h3F;

  // Index width, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Constant modulo by repeated subtraction; only ever called on parameters.
  function automatic int mod_const(input int a, input int m);
    int r;
    r = a;
    while (r >= m) r = r - m;
    return r;
  endfunction

endpackage

// File: rtl/seg7_tick_gen.sv
// Scroll-rate prescaler.
// While en is high it counts 0..TICK_DIV-1 and wraps back to 0; while en is
// low the count holds its value.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   en          count enable
//   tick        high for the cycle in which the count is TICK_DIV-1 and en is high
//   count       current count (only present with SEG7_MARQUEE_BLINK_EN,
//               because the blink phase taps it)
module seg7_tick_gen #(
  parameter  int TICK_DIV = 50_000_000,
  localparam int CW       = $clog2(TICK_DIV)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
`ifdef SEG7_MARQUEE_BLINK_EN
  output logic [CW-1:0] count,
`endif
  output logic          tick
);

  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  assign tick = en && (count_q == LAST);

`ifdef SEG7_MARQUEE_BLINK_EN
  assign count = count_q;
`endif

endmodule

// File: rtl/seg7_marquee.sv
// Scrolling-text driver for NUM_DIGITS active-low 7-segment digits.
// A writable message buffer of MSG_LEN segment codes scrolls across the
// digits. It moves on a prescaler tick while run_i is high, or on a step_i
// pulse.
// Optional feature: when macro SEG7_MARQUEE_BLINK_EN is defined, the module
// gets a blink_i port that blanks the display periodically.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   run_i        auto-scroll on each tick (the prescaler holds while low)
//   dir_i        0 = scroll left (pos+1), 1 = scroll right (pos-1)
//   step_i       advance one position on this edge
//   blink_i      (SEG7_MARQUEE_BLINK_EN only) blink the display
//   wr_en_i, wr_addr_i, wr_data_i  message buffer write; out-of-range
//                                  addresses are dropped
//   hex_o        digit d occupies [7d+6:7d]; d = NUM_DIGITS-1 is leftmost
//   pos_o        current scroll offset
//   wrap_o       one-cycle pulse after pos wraps
module seg7_marquee
  import seg7_pkg::*;
#(
  parameter  int NUM_DIGITS = 4,
  parameter  int MSG_LEN    = 5,
  parameter  int TICK_DIV   = 50_000_000,
  localparam int PW         = idx_w(MSG_LEN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    run_i,
  input  logic                    dir_i,
  input  logic                    step_i,
`ifdef SEG7_MARQUEE_BLINK_EN
  input  logic                    blink_i,
`endif
  input  logic                    wr_en_i,
  input  logic [PW-1:0]           wr_addr_i,
  input  logic [6:0]              wr_data_i,
  output logic [7*NUM_DIGITS-1:0] hex_o,
  output logic [PW-1:0]           pos_o,
  output logic                    wrap_o
);

  localparam logic [PW:0]   LEN_X    = (PW+1)'(MSG_LEN);
  localparam logic [PW-1:0] LAST_POS = PW'(MSG_LEN - 1);

  logic                    presc_en;
  logic                    tick;
  logic                    advance;
  logic [PW-1:0]           pos_q, pos_nxt;
  logic                    wrap_q, wrap_nxt;
  logic [6:0]              msg_q [MSG_LEN];
  logic [7*NUM_DIGITS-1:0] hex_nxt;
  logic [7*NUM_DIGITS-1:0] hex_q;

`ifdef SEG7_MARQUEE_BLINK_EN
  localparam int          CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] HALF = CW'(TICK_DIV/2 - 1);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] presc_count;
  logic          phase_q;

  assign presc_en = run_i | blink_i;

  seg7_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (presc_en),
    .count (presc_count),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
    end else if (!blink_i) begin
      phase_q <= 1'b0;
    end else if (presc_en && (presc_count == HALF || presc_count == LAST)) begin
      phase_q <= ~phase_q;
    end
  end
`else
  assign presc_en = run_i;

  seg7_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (presc_en),
    .tick  (tick)
  );
`endif

  // A step that lands on the same edge as a tick still moves the text only once.
  assign advance = (tick & run_i) | step_i;

  // With MSG_LEN == 1, LAST_POS is 0, so every advance wraps in place.
  always_comb begin
    pos_nxt  = pos_q;
    wrap_nxt = 1'b0;
    if (advance) begin
      if (dir_i) begin
        if (pos_q == '0) begin
          pos_nxt  = LAST_POS;
          wrap_nxt = 1'b1;
        end else begin
          pos_nxt = pos_q - 1'b1;
        end
      end else begin
        if (pos_q == LAST_POS) begin
          pos_nxt  = '0;
          wrap_nxt = 1'b1;
        end else begin
          pos_nxt = pos_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      pos_q  <= pos_nxt;
      wrap_q <= wrap_nxt;
    end
  end

  // Address compare per entry, so an out-of-range address matches nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MSG_LEN; i++) msg_q[i] <= SEG_BLANK;
    end else if (wr_en_i) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        if (wr_addr_i == PW'(i)) msg_q[i] <= wr_data_i;
      end
    end
  end

  // Digit d shows msg[(pos + NUM_DIGITS-1-d) mod MSG_LEN]. The offset is
  // reduced at elaboration time. After that, pos + offset < 2*MSG_LEN, so a
  // single conditional subtract completes the wrap.
  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
    localparam logic [PW:0] OFF = (PW+1)'(mod_const(NUM_DIGITS - 1 - d, MSG_LEN));

    logic [PW:0] sum;
    logic [PW:0] idx;
    logic [6:0]  seg;

    assign sum = {1'b0, pos_q} + OFF;
    assign idx = (sum >= LEN_X) ? sum - LEN_X : sum;

    always_comb begin
      seg = SEG_BLANK;
      for (int i = 0; i < MSG_LEN; i++) begin
        if (idx == (PW+1)'(i)) seg = msg_q[i];
      end
    end

    assign hex_nxt[7*d +: 7] = seg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_q <= '1;
    end else begin
`ifdef SEG7_MARQUEE_BLINK_EN
      hex_q <= phase_q ? '1 : hex_nxt;
`else
      hex_q <= hex_nxt;
`endif
    end
  end

  assign hex_o  = hex_q;
  assign pos_o  = pos_q;
  assign wrap_o = wrap_q;

endmodule

// File: tb/tb_seg7_marquee.sv
module tb_seg7_marquee;

  localparam logic [6:0] H = 7'h09;
  localparam logic [6:0] E = 7'h06;
  localparam logic [6:0] L = 7'h47;
  localparam logic [6:0] O = 7'h40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        run = 1'b0, dir = 1'b0, step = 1'b0, blink = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = 3'd0;
  logic [6:0]  wr_data = 7'h00;
  logic        addr1;
  logic [27:0] hex4;
  logic [41:0] hex6;
  logic [27:0] hex1;
  logic [2:0]  pos4, pos6;
  logic        pos1;
  logic        wrap4, wrap6, wrap1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign addr1 = (wr_addr != 3'd0);

  seg7_marquee #(.NUM_DIGITS(4), .MSG_LEN(5), .TICK_DIV(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .run_i(run), .dir_i(dir), .step_i(step),
`ifdef SEG7_MARQUEE_BLINK_EN
    .blink_i(blink),
`endif
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .hex_o(hex4), .pos_o(pos4), .wrap_o(wrap4));

  seg7_marquee #(.NUM_DIGITS(6), .MSG_LEN(5), .TICK_DIV(4)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .run_i(run), .dir_i(dir), .step_i(step),
`ifdef SEG7_MARQUEE_BLINK_EN
    .blink_i(blink),
`endif
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .hex_o(hex6), .pos_o(pos6), .wrap_o(wrap6));

  seg7_marquee #(.NUM_DIGITS(4), .MSG_LEN(1), .TICK_DIV(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .run_i(run), .dir_i(dir), .step_i(step),
`ifdef SEG7_MARQUEE_BLINK_EN
    .blink_i(blink),
`endif
    .wr_en_i(wr_en), .wr_addr_i(addr1), .wr_data_i(wr_data),
    .hex_o(hex1), .pos_o(pos1), .wrap_o(wrap1));

  // Reference model: message as a plain array, position as an integer, and
  // the digit mapping done with %.
  logic [6:0]  msg_m [5];
  logic [6:0]  msg1_m;
  int          pos_m, cnt_m;
  logic        phase_m;
  logic [41:0] exp4, exp6;
  logic [27:0] exp1;
  logic        expw, expw1;
  logic        adv_m;

  assign adv_m = (run && cnt_m == 3) || step;

  function automatic logic [41:0] disp_m(input int n, input int p);
    logic [41:0] r;
    r = '1;
    for (int d = 0; d < n; d++) r[7*d +: 7] = msg_m[(p + n - 1 - d) % 5];
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) msg_m[i] <= 7'h7F;
      msg1_m  <= 7'h7F;
      pos_m   <= 0;
      cnt_m   <= 0;
      phase_m <= 1'b0;
      exp4    <= '1;
      exp6    <= '1;
      exp1    <= '1;
      expw    <= 1'b0;
      expw1   <= 1'b0;
    end else begin
      exp4  <= phase_m ? '1 : disp_m(4, pos_m);
      exp6  <= phase_m ? '1 : disp_m(6, pos_m);
      exp1  <= phase_m ? '1 : {4{msg1_m}};
      if (run || blink) cnt_m <= (cnt_m + 1) % 4;
      if (adv_m) pos_m <= dir ? (pos_m + 4) % 5 : (pos_m + 1) % 5;
      expw  <= adv_m && (dir ? (pos_m == 0) : (pos_m == 4));
      expw1 <= adv_m;
      if (wr_en && wr_addr < 5) msg_m[wr_addr] <= wr_data;
      if (wr_en && wr_addr == 0) msg1_m <= wr_data;
      if (!blink) phase_m <= 1'b0;
      else if (cnt_m == 1 || cnt_m == 3) phase_m <= ~phase_m;
    end
  end

  logic [27:0] tab [5];

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_hello();
    logic [6:0] w [5];
    w[0] = H; w[1] = E; w[2] = L; w[3] = L; w[4] = O;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = w[i];
      cyc();
    end
    wr_en = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    @(negedge clk);
    checks++; if (hex4 !== 28'hFFFFFFF) begin failures++; $display("FAIL reset_hex4 got=%h exp=%h", hex4, 28'hFFFFFFF); end
    checks++; if (hex6 !== {42{1'b1}}) begin failures++; $display("FAIL reset_hex6 got=%h exp=all_ones", hex6); end
    checks++; if (pos4 !== 3'd0) begin failures++; $display("FAIL reset_pos got=%0d exp=0", pos4); end
    checks++; if (wrap4 !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%b exp=0", wrap4); end
    rst_n = 1'b1;
    cyc();
    checks++; if (hex4 !== 28'hFFFFFFF) begin failures++; $display("FAIL post_reset_blank got=%h exp=%h", hex4, 28'hFFFFFFF); end
  endtask

  task automatic test_hello();
    write_hello();
    checks++; if (hex4 !== tab[0]) begin failures++; $display("FAIL hello_hex4 got=%h exp=%h", hex4, tab[0]); end
    checks++; if (hex6 !== {H, E, L, L, O, H}) begin failures++; $display("FAIL hello_hex6 got=%h exp=%h", hex6, {H, E, L, L, O, H}); end
    checks++; if (hex1 !== {H, H, H, H}) begin failures++; $display("FAIL hello_hex1 got=%h exp=%h", hex1, {H, H, H, H}); end
    repeat (10) cyc();
    checks++; if (pos4 !== 3'd0) begin failures++; $display("FAIL paused_pos got=%0d exp=0", pos4); end
    checks++; if (wrap4 !== 1'b0) begin failures++; $display("FAIL paused_wrap got=%b exp=0", wrap4); end
  endtask

  task automatic test_scroll_left();
    run = 1'b1; dir = 1'b0;
    repeat (3) cyc();
    for (int t = 1; t <= 5; t++) begin
      cyc();
      checks++; if (pos4 !== 3'(t % 5)) begin failures++; $display("FAIL left_pos t=%0d got=%0d exp=%0d", t, pos4, t % 5); end
      checks++; if (wrap4 !== (t == 5)) begin failures++; $display("FAIL left_wrap t=%0d got=%b exp=%b", t, wrap4, t == 5); end
      cyc();
      checks++; if (hex4 !== tab[t % 5]) begin failures++; $display("FAIL left_hex t=%0d got=%h exp=%h", t, hex4, tab[t % 5]); end
      checks++; if (wrap4 !== 1'b0) begin failures++; $display("FAIL left_wrap_clear t=%0d got=%b exp=0", t, wrap4); end
      cyc();
      cyc();
    end
  endtask

  task automatic test_scroll_right();
    dir = 1'b1;
    cyc();
    checks++; if (pos4 !== 3'd4) begin failures++; $display("FAIL right_pos got=%0d exp=4", pos4); end
    checks++; if (wrap4 !== 1'b1) begin failures++; $display("FAIL right_wrap got=%b exp=1", wrap4); end
    cyc();
    checks++; if (hex4 !== tab[4]) begin failures++; $display("FAIL right_hex got=%h exp=%h", hex4, tab[4]); end
    cyc();
    cyc();
    step = 1'b1;
    cyc();
    step = 1'b0;
    checks++; if (pos4 !== 3'd3) begin failures++; $display("FAIL coincident_pos got=%0d exp=3", pos4); end
    cyc();
    cyc();
    checks++; if (pos4 !== 3'd3) begin failures++; $display("FAIL coincident_hold got=%0d exp=3", pos4); end
    checks++; if (hex4 !== tab[3]) begin failures++; $display("FAIL coincident_hex got=%h exp=%h", hex4, tab[3]); end
    run = 1'b0;
  endtask

  task automatic test_step();
    int exp_pos [4];
    exp_pos[0] = 4; exp_pos[1] = 0; exp_pos[2] = 1; exp_pos[3] = 2;
    dir = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step = 1'b1;
      cyc();
      step = 1'b0;
      checks++; if (pos4 !== 3'(exp_pos[i])) begin failures++; $display("FAIL step_pos i=%0d got=%0d exp=%0d", i, pos4, exp_pos[i]); end
      checks++; if (wrap4 !== (i == 1)) begin failures++; $display("FAIL step_wrap i=%0d got=%b exp=%b", i, wrap4, i == 1); end
      cyc();
    end
    checks++; if (hex4 !== tab[2]) begin failures++; $display("FAIL step_hex got=%h exp=%h", hex4, tab[2]); end
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 7'h00;
    cyc();
    wr_addr = 3'd7;
    cyc();
    wr_en = 1'b0;
    cyc();
    checks++; if (hex4 !== tab[2]) begin failures++; $display("FAIL bad_addr_hex got=%h exp=%h", hex4, tab[2]); end
    checks++; if (hex6 !== exp6) begin failures++; $display("FAIL bad_addr_hex6 got=%h exp=%h", hex6, exp6); end
  endtask

  task automatic test_msglen1();
    dir = 1'b1;
    step = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (wrap1 !== 1'b1) begin failures++; $display("FAIL len1_wrap i=%0d got=%b exp=1", i, wrap1); end
      checks++; if (pos1 !== 1'b0) begin failures++; $display("FAIL len1_pos i=%0d got=%b exp=0", i, pos1); end
    end
    step = 1'b0;
    cyc();
    checks++; if (wrap1 !== 1'b0) begin failures++; $display("FAIL len1_wrap_clear got=%b exp=0", wrap1); end
    checks++; if (pos4 !== 3'd4) begin failures++; $display("FAIL back_to_back_pos got=%0d exp=4", pos4); end
  endtask

  task automatic test_reset_mid();
    run = 1'b1;
    repeat (6) cyc();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (hex4 !== 28'hFFFFFFF) begin failures++; $display("FAIL midreset_hex4 got=%h exp=%h", hex4, 28'hFFFFFFF); end
    checks++; if (hex1 !== 28'hFFFFFFF) begin failures++; $display("FAIL midreset_hex1 got=%h exp=%h", hex1, 28'hFFFFFFF); end
    checks++; if (pos4 !== 3'd0) begin failures++; $display("FAIL midreset_pos got=%0d exp=0", pos4); end
    checks++; if (wrap4 !== 1'b0) begin failures++; $display("FAIL midreset_wrap got=%b exp=0", wrap4); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) cyc();
    checks++; if (hex4 !== 28'hFFFFFFF) begin failures++; $display("FAIL after_midreset_hex got=%h exp=%h", hex4, 28'hFFFFFFF); end
    run = 1'b0;
  endtask

`ifdef SEG7_MARQUEE_BLINK_EN
  task automatic test_blink();
    logic [2:0] p0;
    write_hello();
    p0 = pos4;
    blink = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      checks++; if (hex4 !== exp4[27:0]) begin failures++; $display("FAIL blink_hex i=%0d got=%h exp=%h", i, hex4, exp4[27:0]); end
      checks++; if (pos4 !== p0) begin failures++; $display("FAIL blink_pos i=%0d got=%0d exp=%0d", i, pos4, p0); end
    end
    blink = 1'b0;
    repeat (2) cyc();
    for (int i = 0; i < 6; i++) begin
      cyc();
      checks++; if (hex4 !== tab[0]) begin failures++; $display("FAIL blink_off_hex i=%0d got=%h exp=%h", i, hex4, tab[0]); end
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      run     = ($urandom_range(0, 3) != 0);
      dir     = ($urandom_range(0, 7) == 0) ? ~dir : dir;
      step    = ($urandom_range(0, 5) == 0);
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = 7'($urandom);
`ifdef SEG7_MARQUEE_BLINK_EN
      if ($urandom_range(0, 15) == 0) blink = ~blink;
`endif
      cyc();
      checks++; if (hex4 !== exp4[27:0]) begin failures++; $display("FAIL rand_hex4 i=%0d got=%h exp=%h", i, hex4, exp4[27:0]); end
      checks++; if (hex6 !== exp6) begin failures++; $display("FAIL rand_hex6 i=%0d got=%h exp=%h", i, hex6, exp6); end
      checks++; if (hex1 !== exp1) begin failures++; $display("FAIL rand_hex1 i=%0d got=%h exp=%h", i, hex1, exp1); end
      checks++; if (pos4 !== 3'(pos_m) || pos6 !== 3'(pos_m)) begin failures++; $display("FAIL rand_pos i=%0d got=%0d/%0d exp=%0d", i, pos4, pos6, pos_m); end
      checks++; if (wrap4 !== expw || wrap6 !== expw) begin failures++; $display("FAIL rand_wrap i=%0d got=%b/%b exp=%b", i, wrap4, wrap6, expw); end
      checks++; if (wrap1 !== expw1 || pos1 !== 1'b0) begin failures++; $display("FAIL rand_len1 i=%0d got=%b/%b exp=%b/0", i, wrap1, pos1, expw1); end
    end
    run = 1'b0; step = 1'b0; wr_en = 1'b0; blink = 1'b0;
    cyc();
  endtask

  initial begin
    tab[0] = {H, E, L, L};
    tab[1] = {E, L, L, O};
    tab[2] = {L, L, O, H};
    tab[3] = {L, O, H, E};
    tab[4] = {O, H, E, L};
    test_reset();
    test_hello();
    test_scroll_left();
    test_scroll_right();
    test_step();
    test_msglen1();
    test_reset_mid();
`ifdef SEG7_MARQUEE_BLINK_EN
    test_blink();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
